// File: rtl/uart_tx_buff_if.sv
// Write-side and serial-side signals of the buffered UART transmitter.
// master: the byte producer; slave: the transmitter.
interface uart_tx_buff_if #(
    parameter int DEPTH = 16
);
    logic                     wr_en;
    logic [7:0]               wr_data;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;
    logic                     tx;
    logic                     busy;
    logic                     tx_done;

    modport master (
        output wr_en, wr_data,
        input  full, empty, level, overflow, tx, busy, tx_done
    );

    modport slave (
        input  wr_en, wr_data,
        output full, empty, level, overflow, tx, busy, tx_done
    );
endinterface

// File: rtl/uart_tx_buff.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding a start/data/stop serializer.
// Back-to-back frames are emitted with no idle cycles while the FIFO is non-empty.
module uart_tx_buff #(
    parameter int CLK_FREQ  = 12000000,
    parameter int BAUD      = 9600,
    parameter int DEPTH     = 16,
    parameter int STOP_BITS = 1
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_buff_if.slave bus
);
    localparam int DIV = CLK_FREQ / BAUD;
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int CW  = $clog2(DIV + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level;
    logic          overflow;
    logic [1:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    logic          tx_q;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic          bit_end;
    logic          last_stop;

    assign full      = (level == LW'(DEPTH));
    assign empty     = (level == '0);
    assign push      = bus.wr_en && !full;
    assign bit_end   = (baud_cnt == CW'(DIV - 1));
    assign last_stop = (state == STOP) && bit_end && (bit_idx == 3'(STOP_BITS - 1));
    // Pop either from idle or on the very last stop cycle, so the next start bit follows with no gap.
    assign pop       = !empty && ((state == IDLE) || last_stop);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= bus.wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            // A dropped write is flagged even if a pop frees a slot on the same edge.
            if (bus.wr_en && full) overflow <= 1'b1;
        end
    end

    // The serializer keeps its own copy of the byte, so the FIFO slot is free right after the pop.
    always_ff @(posedge clk) begin
        if (pop)
            shift <= mem[rd_ptr];
        else if (state == DATA && bit_end)
            shift <= {1'b0, shift[7:1]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx_q     <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    baud_cnt <= '0;
                    bit_idx  <= '0;
                    if (!empty) begin
                        state <= START;
                        tx_q  <= 1'b0;
                    end
                end
                START: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                        state    <= DATA;
                        tx_q     <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            bit_idx <= '0;
                            state   <= STOP;
                            tx_q    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx_q    <= shift[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    // STOP: bit_idx counts stop bits here
                    if (bit_end) begin
                        baud_cnt <= '0;
                        if (last_stop) begin
                            bit_idx <= '0;
                            if (!empty) begin
                                state <= START;
                                tx_q  <= 1'b0;
                            end else begin
                                state <= IDLE;
                                tx_q  <= 1'b1;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.level    = level;
    assign bus.overflow = overflow;
    assign bus.tx       = tx_q;
    assign bus.busy     = (state != IDLE);
    assign bus.tx_done  = last_stop;
endmodule

// File: tb/tb_uart_tx_buff.sv
// Directed bench for uart_tx_buff: a fast 1-stop instance (DIV=10) for FIFO/framing
// scenarios and a default-clock 2-stop, 2400-baud instance (DIV=5000).
module tb_uart_tx_buff;
    localparam int DIV_A   = 10;      // 12 MHz / 1.2 Mbaud
    localparam int FRAME_A = 100;     // 10 bits * 10
    localparam int DIV_B   = 5000;    // 12 MHz / 2400 baud
    localparam int FRAME_B = 55000;   // 11 bits * 5000

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   vec_cnt = 0;
    int   err_cnt = 0;

    logic [7:0] rx_q[$];
    int         start_q[$];
    logic       stop_q[$];

    uart_tx_buff_if #(.DEPTH(16)) bus_a ();
    uart_tx_buff_if #(.DEPTH(4))  bus_b ();

    uart_tx_buff #(.CLK_FREQ(12000000), .BAUD(1200000), .DEPTH(16), .STOP_BITS(1)) dut_a (
        .clk(clk), .rst(rst), .bus(bus_a)
    );
    uart_tx_buff #(.CLK_FREQ(12000000), .BAUD(2400), .DEPTH(4), .STOP_BITS(2)) dut_b (
        .clk(clk), .rst(rst), .bus(bus_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Line receiver for instance A: samples mid-bit, logs byte, start cycle and stop level.
    initial begin
        logic [7:0] mb;
        int         mt;
        forever begin
            @(negedge clk);
            if (!rst && bus_a.tx === 1'b0) begin
                mt = cyc;
                repeat (DIV_A / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (DIV_A) @(negedge clk);
                    mb[i] = bus_a.tx;
                end
                repeat (DIV_A) @(negedge clk);
                rx_q.push_back(mb);
                start_q.push_back(mt);
                stop_q.push_back(bus_a.tx);
            end
        end
    end

    task automatic get_rx(input string tag, input logic [7:0] exp, output int t0);
        int n;
        n = 0;
        while (rx_q.size() == 0 && n < 4 * FRAME_A) begin
            @(negedge clk);
            n++;
        end
        if (rx_q.size() == 0) begin
            chk({tag, " timeout"}, 32'(rx_q.size()), 1);
            t0 = -1;
        end else begin
            t0 = start_q.pop_front();
            chk(tag, rx_q.pop_front(), exp);
            chk({tag, " stop"}, stop_q.pop_front(), 1);
        end
    endtask

    initial begin
        #(2000000 * 10);
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  fr_a;
        logic [10:0] fr_b;
        int t0, t1, t2, lows, hi_cnt;

        bus_a.wr_en = 1'b0; bus_a.wr_data = 8'h00;
        bus_b.wr_en = 1'b0; bus_b.wr_data = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst tx", bus_a.tx, 1);
        chk("rst busy", bus_a.busy, 0);
        chk("rst tx_done", bus_a.tx_done, 0);
        chk("rst level", bus_a.level, 0);
        chk("rst empty", bus_a.empty, 1);
        chk("rst full", bus_a.full, 0);
        chk("rst overflow", bus_a.overflow, 0);
        chk("rst b tx", bus_b.tx, 1);
        chk("rst b level", bus_b.level, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte 0xA5, full waveform check
        bus_a.wr_en = 1'b1; bus_a.wr_data = 8'hA5;
        @(negedge clk);
        bus_a.wr_en = 1'b0;
        chk("lat level1", bus_a.level, 1);
        chk("lat tx idle", bus_a.tx, 1);
        chk("lat busy0", bus_a.busy, 0);
        @(negedge clk);
        chk("lat tx start", bus_a.tx, 0);
        chk("lat busy1", bus_a.busy, 1);
        chk("lat empty", bus_a.empty, 1);
        fr_a = {1'b1, 8'hA5, 1'b0};
        for (int j = 0; j < FRAME_A; j++) begin
            chk("a5 tx", bus_a.tx, fr_a[j / DIV_A]);
            chk("a5 tx_done", bus_a.tx_done, (j == FRAME_A - 1) ? 1 : 0);
            @(negedge clk);
        end
        chk("a5 end busy", bus_a.busy, 0);
        chk("a5 end tx", bus_a.tx, 1);
        chk("a5 end empty", bus_a.empty, 1);
        chk("a5 end tx_done", bus_a.tx_done, 0);
        get_rx("a5 rx", 8'hA5, t0);

        // Burst 0x00, 0xFF, 0x55
        bus_a.wr_en = 1'b1; bus_a.wr_data = 8'h00;
        @(negedge clk);
        chk("burst level a", bus_a.level, 1);
        bus_a.wr_data = 8'hFF;
        @(negedge clk);
        chk("burst level b", bus_a.level, 1);
        bus_a.wr_data = 8'h55;
        @(negedge clk);
        bus_a.wr_en = 1'b0;
        chk("burst level c", bus_a.level, 2);
        @(negedge clk);
        chk("burst level peak", bus_a.level, 2);
        get_rx("burst rx0", 8'h00, t0);
        get_rx("burst rx1", 8'hFF, t1);
        get_rx("burst rx2", 8'h55, t2);
        chk("burst gap01", 32'(t1 - t0), FRAME_A);
        chk("burst gap12", 32'(t2 - t1), FRAME_A);
        repeat (DIV_A) @(negedge clk);
        chk("burst idle busy", bus_a.busy, 0);

        // Overflow: 18 back-to-back writes 0x10..0x21
        bus_a.wr_en = 1'b1;
        for (int k = 0; k < 18; k++) begin
            bus_a.wr_data = 8'(8'h10 + k);
            @(negedge clk);
            if (k == 15) begin
                chk("ovf full before", bus_a.full, 0);
                chk("ovf level 15", bus_a.level, 15);
            end
            if (k == 16) begin
                chk("ovf full", bus_a.full, 1);
                chk("ovf level 16", bus_a.level, 16);
                chk("ovf flag clear", bus_a.overflow, 0);
            end
        end
        bus_a.wr_en = 1'b0;
        chk("ovf flag set", bus_a.overflow, 1);
        chk("ovf level hold", bus_a.level, 16);
        for (int k = 0; k < 17; k++) get_rx("ovf rx", 8'(8'h10 + k), t0);
        lows = 0;
        for (int j = 0; j < 3 * FRAME_A; j++) begin
            @(negedge clk);
            if (bus_a.tx === 1'b0) lows++;
        end
        chk("ovf no 0x21", lows, 0);
        chk("ovf sticky", bus_a.overflow, 1);
        chk("ovf drained", bus_a.empty, 1);

        // Write on the final stop cycle while one byte is queued
        bus_a.wr_en = 1'b1; bus_a.wr_data = 8'h5A;
        @(negedge clk);
        bus_a.wr_data = 8'hE7;
        @(negedge clk);
        bus_a.wr_en = 1'b0;
        chk("sim level pre", bus_a.level, 1);
        t0 = 0;
        while (bus_a.tx_done !== 1'b1 && t0 < 2 * FRAME_A) begin
            @(negedge clk);
            t0++;
        end
        chk("sim tx_done seen", bus_a.tx_done, 1);
        chk("sim level at done", bus_a.level, 1);
        bus_a.wr_en = 1'b1; bus_a.wr_data = 8'h3C;
        @(negedge clk);
        bus_a.wr_en = 1'b0;
        chk("sim level post", bus_a.level, 1);
        chk("sim tx start", bus_a.tx, 0);
        chk("sim busy", bus_a.busy, 1);
        get_rx("sim rx0", 8'h5A, t0);
        get_rx("sim rx1", 8'hE7, t1);
        get_rx("sim rx2", 8'h3C, t2);
        chk("sim gap01", 32'(t1 - t0), FRAME_A);
        chk("sim gap12", 32'(t2 - t1), FRAME_A);

        // Reset during data bit 3 of 0xC3 with two bytes queued
        repeat (DIV_A) @(negedge clk);
        bus_a.wr_en = 1'b1; bus_a.wr_data = 8'hC3;
        @(negedge clk);
        bus_a.wr_data = 8'h11;
        @(negedge clk);
        bus_a.wr_data = 8'h22;
        @(negedge clk);
        bus_a.wr_en = 1'b0;
        chk("mid level 2", bus_a.level, 2);
        repeat (4 * DIV_A + 2) @(negedge clk);
        chk("mid bit3", bus_a.tx, 0);
        #1 rst = 1'b1;
        #1;
        chk("mid rst tx", bus_a.tx, 1);
        chk("mid rst level", bus_a.level, 0);
        chk("mid rst busy", bus_a.busy, 0);
        chk("mid rst empty", bus_a.empty, 1);
        chk("mid rst overflow", bus_a.overflow, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        lows = 0;
        for (int j = 0; j < 3 * FRAME_A; j++) begin
            @(negedge clk);
            if (bus_a.tx !== 1'b1) lows++;
        end
        chk("mid no resume", lows, 0);
        chk("mid busy after", bus_a.busy, 0);
        rx_q.delete(); start_q.delete(); stop_q.delete();

        // Two stop bits at 2400 baud: 0x81
        bus_b.wr_en = 1'b1; bus_b.wr_data = 8'h81;
        @(negedge clk);
        bus_b.wr_en = 1'b0;
        chk("b level1", bus_b.level, 1);
        @(negedge clk);
        chk("b busy", bus_b.busy, 1);
        fr_b = {2'b11, 8'h81, 1'b0};
        hi_cnt = 0;
        for (int j = 0; j < FRAME_B; j++) begin
            chk("b tx", bus_b.tx, fr_b[j / DIV_B]);
            chk("b tx_done", bus_b.tx_done, (j == FRAME_B - 1) ? 1 : 0);
            if (j >= 9 * DIV_B && bus_b.tx === 1'b1) hi_cnt++;
            @(negedge clk);
        end
        chk("b stop len", hi_cnt, 10000);
        chk("b end busy", bus_b.busy, 0);
        chk("b end tx", bus_b.tx, 1);
        chk("b end empty", bus_b.empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end
endmodule
